// File: rtl/fir_trig_coeff_seq_pkg.sv
// Shared definitions for the FIR trigger coefficient reload sequencer.
package fir_trig_coeff_seq_pkg;

  localparam int COEFF_W     = 64;
  localparam int STAGE_DEPTH = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ARST,
    ST_WRITE,
    ST_READ,
    ST_RWAIT,
    ST_BRST,
    ST_SETTLE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_MISMATCH   = 2'd1;
  localparam logic [1:0] ERR_RD_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_FV_TIMEOUT = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/coeff_stage_ram.sv
// 4x64 coefficient staging RAM: synchronous write, asynchronous read, no reset.
module coeff_stage_ram
  import fir_trig_coeff_seq_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [1:0]         wr_adr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic [1:0]         rd_adr,
  output logic [COEFF_W-1:0] rd_data
);

  logic [COEFF_W-1:0] mem_q [STAGE_DEPTH];

  // Host writes land on the rising edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_adr] <= wr_data;
  end

  assign rd_data = mem_q[rd_adr];

endmodule

// File: rtl/fir_trig_coeff_seq.sv
// Coefficient reload sequencer: gates the filter, resets and rewrites its
// coefficients from the staging RAM, verifies them by readback, then waits
// for the filter output to become valid again.
//
// state  | meaning
// IDLE   | waiting for start; staging RAM writable
// HOLD   | valid_gate low, letting the filter pipeline drain (HOLD_CYC cycles)
// ARST   | coeff_in_areset asserted (2 cycles)
// WRITE  | one coefficient word per cycle, addresses 0..3
// READ   | one-cycle readback request for the current address
// RWAIT  | waiting for readback data, compared against the staged word
// BRST   | bsum_reset pulse, valid_gate released
// SETTLE | waiting for fvalid_out (first 4 cycles ignored)
// ERR    | one-cycle failure state, err/err_code latched
module fir_trig_coeff_seq
  import fir_trig_coeff_seq_pkg::*;
#(
  parameter int HOLD_CYC   = 8,
  parameter int RD_TIMEOUT = 16,
  parameter int FV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_we,
  input  logic [1:0]         host_adr,
  input  logic [COEFF_W-1:0] host_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               valid_gate,
  output logic               coeff_in_areset,
  output logic [3:0]         coeff_in_we,
  output logic [1:0]         coeff_in_adr,
  output logic [COEFF_W-1:0] coeff_in_data,
  output logic               coeff_in_read,
  input  logic [3:0]         coeff_out_valid,
  input  logic [COEFF_W-1:0] coeff_out_data,
  output logic               bsum_reset,
  input  logic               fvalid_out
);

  localparam int CNT_W = $clog2(max3(HOLD_CYC, RD_TIMEOUT, FV_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ARST_LOAD = CNT_W'(1);
  // RWAIT starts the cycle after the read pulse, so it runs RD_TIMEOUT-1 cycles.
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] FV_LOAD   = CNT_W'(FV_TIMEOUT - 1);
  // fvalid_out is only honoured once 4 SETTLE cycles have elapsed.
  localparam logic [CNT_W-1:0] FV_ARMED  = CNT_W'(FV_TIMEOUT - 5);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [1:0]         addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               valid_gate_q, valid_gate_d;
  logic               areset_q, areset_d;
  logic [3:0]         we_q, we_d;
  logic [1:0]         adr_q, adr_d;
  logic [COEFF_W-1:0] data_q, data_d;
  logic               read_q, read_d;
  logic               bsum_q, bsum_d;
  logic [1:0]         stage_rd_adr;
  logic [COEFF_W-1:0] stage_rd_data;

  coeff_stage_ram u_stage (
    .clk     (clk),
    .we      (host_we && !busy_q),
    .wr_adr  (host_adr),
    .wr_data (host_data),
    .rd_adr  (stage_rd_adr),
    .rd_data (stage_rd_data)
  );

  assign cnt_dec = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);

  // Staging read address: next word to write in ARST/WRITE, word under test in RWAIT.
  always_comb begin
    stage_rd_adr = 2'd0;
    if (state_q == ST_WRITE)      stage_rd_adr = addr_q + 2'd1;
    else if (state_q == ST_RWAIT) stage_rd_adr = addr_q;
  end

  // Next-state and next-output decode; outputs are registered with the state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    valid_gate_d = valid_gate_q;
    areset_d     = 1'b0;
    we_d         = 4'h0;
    adr_d        = adr_q;
    data_d       = data_q;
    read_d       = 1'b0;
    bsum_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d      = ST_HOLD;
        cnt_d        = HOLD_LOAD;
        busy_d       = 1'b1;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;
        valid_gate_d = 1'b0;
      end
      ST_HOLD: if (cnt_q == '0) begin
        state_d  = ST_ARST;
        cnt_d    = ARST_LOAD;
        areset_d = 1'b1;
      end else begin
        cnt_d = cnt_dec;
      end
      ST_ARST: if (cnt_q == '0) begin
        state_d = ST_WRITE;
        addr_d  = 2'd0;
        we_d    = 4'hF;
        adr_d   = 2'd0;
        data_d  = stage_rd_data;
      end else begin
        cnt_d    = cnt_dec;
        areset_d = 1'b1;
      end
      ST_WRITE: if (addr_q == 2'd3) begin
        state_d = ST_READ;
        addr_d  = 2'd0;
        adr_d   = 2'd0;
        read_d  = 1'b1;
      end else begin
        addr_d = addr_q + 2'd1;
        we_d   = 4'hF;
        adr_d  = addr_q + 2'd1;
        data_d = stage_rd_data;
      end
      ST_READ: begin
        state_d = ST_RWAIT;
        cnt_d   = RD_LOAD;
      end
      ST_RWAIT: if (|coeff_out_valid) begin
        if (coeff_out_data != stage_rd_data) begin
          state_d      = ST_ERR;
          err_d        = 1'b1;
          err_code_d   = ERR_MISMATCH;
          valid_gate_d = 1'b1;
        end else if (addr_q == 2'd3) begin
          state_d      = ST_BRST;
          bsum_d       = 1'b1;
          valid_gate_d = 1'b1;
        end else begin
          state_d = ST_READ;
          addr_d  = addr_q + 2'd1;
          adr_d   = addr_q + 2'd1;
          read_d  = 1'b1;
        end
      end else if (cnt_q == '0) begin
        state_d      = ST_ERR;
        err_d        = 1'b1;
        err_code_d   = ERR_RD_TIMEOUT;
        valid_gate_d = 1'b1;
      end else begin
        cnt_d = cnt_dec;
      end
      ST_BRST: begin
        state_d = ST_SETTLE;
        cnt_d   = FV_LOAD;
      end
      ST_SETTLE: if (fvalid_out && (cnt_q <= FV_ARMED)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else if (cnt_q == '0) begin
        state_d    = ST_ERR;
        err_d      = 1'b1;
        err_code_d = ERR_FV_TIMEOUT;
      end else begin
        cnt_d = cnt_dec;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs; reset aborts any sequence silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      valid_gate_q <= 1'b1;
      areset_q     <= 1'b0;
      we_q         <= 4'h0;
      adr_q        <= 2'd0;
      data_q       <= '0;
      read_q       <= 1'b0;
      bsum_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      valid_gate_q <= valid_gate_d;
      areset_q     <= areset_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      data_q       <= data_d;
      read_q       <= read_d;
      bsum_q       <= bsum_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign err_code        = err_code_q;
  assign valid_gate      = valid_gate_q;
  assign coeff_in_areset = areset_q;
  assign coeff_in_we     = we_q;
  assign coeff_in_adr    = adr_q;
  assign coeff_in_data   = data_q;
  assign coeff_in_read   = read_q;
  assign bsum_reset      = bsum_q;

endmodule

// File: tb/tb_fir_trig_coeff_seq.sv
// Scoreboard bench for fir_trig_coeff_seq: stimulus pushes the expected
// event sequence, a monitor pops and compares as the DUT emits events, and a
// small filter model echoes readbacks and raises fvalid_out.
module tb_fir_trig_coeff_seq;

  localparam int EV_WR   = 1;
  localparam int EV_RD   = 2;
  localparam int EV_BSUM = 3;
  localparam int EV_DONE = 4;
  localparam int EV_ERR  = 5;

  typedef struct {
    int          kind;
    int          adr;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_we = 1'b0;
  logic [1:0]  host_adr = 2'd0;
  logic [63:0] host_data = '0;
  logic        start = 1'b0;
  logic        busy, done, err, valid_gate, coeff_in_areset, coeff_in_read, bsum_reset;
  logic [1:0]  err_code, coeff_in_adr;
  logic [3:0]  coeff_in_we;
  logic [63:0] coeff_in_data;
  logic [3:0]  coeff_out_valid;
  logic [63:0] coeff_out_data;
  logic        fvalid_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t exp_q[$];
  logic [63:0] stage_m [4];
  logic [63:0] filt_mem [4];

  int rb_mode = 0;  // 0 echo, 1 corrupt bit 0 of address 2, 2 never answer
  bit fv_en = 1'b1;
  int start_cyc, first_we_cyc, rd_cyc, bsum_cyc, err_cyc, done_cyc;

  fir_trig_coeff_seq dut (
    .clk(clk), .reset(reset), .host_we(host_we), .host_adr(host_adr),
    .host_data(host_data), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .valid_gate(valid_gate), .coeff_in_areset(coeff_in_areset),
    .coeff_in_we(coeff_in_we), .coeff_in_adr(coeff_in_adr), .coeff_in_data(coeff_in_data),
    .coeff_in_read(coeff_in_read), .coeff_out_valid(coeff_out_valid),
    .coeff_out_data(coeff_out_data), .bsum_reset(bsum_reset), .fvalid_out(fvalid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic got(input int kind, input int adr, input logic [63:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected kind=%0d adr=%0d data=%h with nothing expected", kind, adr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.adr != adr || e.data !== data) begin
        errors++;
        $display("FAIL sb_event actual kind=%0d adr=%0d data=%h required kind=%0d adr=%0d data=%h",
                 kind, adr, data, e.kind, e.adr, e.data);
      end
    end
  endtask

  task automatic push(input int kind, input int adr, input logic [63:0] data);
    ev_t e;
    e.kind = kind; e.adr = adr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_writes_reads(input int n_reads);
    for (int a = 0; a < 4; a++) push(EV_WR, a, stage_m[a]);
    for (int a = 0; a < n_reads; a++) push(EV_RD, a, 64'd0);
  endtask

  task automatic push_full_run();
    push_writes_reads(4);
    push(EV_BSUM, 0, 64'd0);
    push(EV_DONE, 0, 64'd0);
  endtask

  task automatic host_drive(input int adr, input logic [63:0] data);
    @(negedge clk);
    host_we = 1'b1; host_adr = 2'(adr); host_data = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic load_stage();
    logic [63:0] w [4];
    w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
    w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
    for (int a = 0; a < 4; a++) begin
      host_drive(a, w[a]);
      stage_m[a] = w[a];
    end
  endtask

  task automatic pulse_start();
    first_we_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (busy) begin
      errors++;
      $display("FAIL %s busy still high after 400 cycles", name);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_valid_gate"}, valid_gate, 1);
    chk({tag, "_areset"}, coeff_in_areset, 0);
    chk({tag, "_we"}, coeff_in_we, 0);
    chk({tag, "_adr"}, coeff_in_adr, 0);
    chk({tag, "_data"}, coeff_in_data, 0);
    chk({tag, "_read"}, coeff_in_read, 0);
    chk({tag, "_bsum"}, bsum_reset, 0);
  endtask

  // Monitor: turns DUT output activity into scoreboard events.
  initial begin
    logic err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (coeff_in_we != 4'h0) begin
        if (first_we_cyc < 0) first_we_cyc = cyc;
        chk("we_all_filters", coeff_in_we, 4'hF);
        got(EV_WR, int'(coeff_in_adr), coeff_in_data);
      end
      if (coeff_in_read) begin
        rd_cyc = cyc;
        got(EV_RD, int'(coeff_in_adr), 64'd0);
      end
      if (bsum_reset) begin
        bsum_cyc = cyc;
        got(EV_BSUM, 0, 64'd0);
      end
      if (done) begin
        done_cyc = cyc;
        got(EV_DONE, 0, 64'd0);
      end
      if (err && !err_prev) begin
        err_cyc = cyc;
        got(EV_ERR, int'(err_code), 64'd0);
        chk("err_valid_gate", valid_gate, 1);
        chk("err_areset", coeff_in_areset, 0);
      end
      err_prev = err;
    end
  end

  // Filter model: captures writes, echoes reads 3 cycles later, raises fvalid.
  initial begin
    bit          rd_armed = 1'b0;
    bit          fv_armed = 1'b0;
    int          rd_due = 0;
    int          fv_due = 0;
    int          rd_adr_m = 0;
    logic [63:0] d;
    coeff_out_valid = 4'h0;
    coeff_out_data  = '0;
    fvalid_out      = 1'b0;
    forever begin
      @(negedge clk);
      coeff_out_valid = 4'h0;
      if (rd_armed && cyc == rd_due) begin
        rd_armed = 1'b0;
        if (rb_mode != 2) begin
          d = filt_mem[rd_adr_m];
          if (rb_mode == 1 && rd_adr_m == 2) d[0] = ~d[0];
          coeff_out_data  = d;
          coeff_out_valid = 4'b0001 << rd_adr_m;
        end
      end
      if (coeff_in_we != 4'h0) filt_mem[coeff_in_adr] = coeff_in_data;
      if (coeff_in_read) begin
        rd_armed = 1'b1; rd_due = cyc + 3; rd_adr_m = int'(coeff_in_adr);
      end
      if (reset) rd_armed = 1'b0;
      if (done || err || reset) fv_armed = 1'b0;
      if (bsum_reset) begin
        fv_armed = 1'b1; fv_due = cyc + 10;
      end
      fvalid_out = fv_en && fv_armed && (cyc >= fv_due);
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Nominal reload.
    load_stage();
    push_full_run();
    pulse_start();
    chk("accept_busy", busy, 1);
    chk("accept_valid_gate", valid_gate, 0);
    wait_idle("nominal");
    chk("nominal_first_we_latency", first_we_cyc - start_cyc, 11);
    chk("nominal_done_after_bsum", done_cyc - bsum_cyc, 11);
    chk("nominal_err", err, 0);
    chk("nominal_valid_gate", valid_gate, 1);
    chk("nominal_drained", exp_q.size(), 0);

    // Readback mismatch on address 2.
    rb_mode = 1;
    push_writes_reads(3);
    push(EV_ERR, 1, 64'd0);
    pulse_start();
    wait_idle("mismatch");
    chk("mismatch_err", err, 1);
    chk("mismatch_code", err_code, 1);
    chk("mismatch_valid_gate", valid_gate, 1);
    chk("mismatch_busy", busy, 0);
    chk("mismatch_drained", exp_q.size(), 0);

    // Readback never answered.
    rb_mode = 2;
    push_writes_reads(1);
    push(EV_ERR, 2, 64'd0);
    pulse_start();
    wait_idle("rd_timeout");
    chk("rd_timeout_code", err_code, 2);
    chk("rd_timeout_latency", err_cyc - rd_cyc, 16);
    chk("rd_timeout_drained", exp_q.size(), 0);

    // fvalid_out never rises, then a fresh start clears err.
    rb_mode = 0;
    fv_en = 1'b0;
    push_writes_reads(4);
    push(EV_BSUM, 0, 64'd0);
    push(EV_ERR, 3, 64'd0);
    pulse_start();
    wait_idle("fv_timeout");
    chk("fv_timeout_code", err_code, 3);
    chk("fv_timeout_latency", err_cyc - bsum_cyc, 65);
    chk("fv_timeout_drained", exp_q.size(), 0);
    fv_en = 1'b1;
    push_full_run();
    pulse_start();
    chk("restart_err_clear", err, 0);
    chk("restart_code_clear", err_code, 0);
    wait_idle("restart");
    chk("restart_err", err, 0);
    chk("restart_drained", exp_q.size(), 0);

    // Reset while writing address 1.
    push(EV_WR, 0, stage_m[0]);
    push(EV_WR, 1, stage_m[1]);
    pulse_start();
    n = 0;
    while (!(coeff_in_we != 4'h0 && coeff_in_adr == 2'd1) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL midwrite_reset address 1 write not seen within 100 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("midwrite_reset");
    repeat (5) @(negedge clk);
    chk("midwrite_idle_busy", busy, 0);
    chk("midwrite_drained", exp_q.size(), 0);

    // start/host_we ignored while busy; start right after done accepted.
    load_stage();
    push_full_run();
    pulse_start();
    pulse_start();
    host_drive(0, 64'hDEAD_BEEF_DEAD_BEEF);
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    if (!done) begin
      errors++;
      $display("FAIL busy_ignore done not seen within 400 cycles");
    end
    push_full_run();
    pulse_start();
    chk("start_after_done_busy", busy, 1);
    wait_idle("start_after_done");
    repeat (20) @(negedge clk);
    chk("busy_ignore_idle", busy, 0);
    chk("busy_ignore_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
